// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a load/store port. One transaction outstanding at a time; data wins
// ties unless it has already taken MAX_DSTREAK grants in a row while fetch
// was waiting. A hung memory is turned into an error response after TIMEOUT
// cycles so the core can recover.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                rstn,
    // instruction fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_err,
    // load/store port
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_err,
    // memory port
    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_DSTREAK + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     streak, streak_nxt;
    logic [TW-1:0]     tcnt, tcnt_nxt, tcnt_inc;
    logic              owner_d, owner_d_nxt;
    logic              done, tmo;
    logic [DATA_W-1:0] rsp_data;

    logic              mem_req_nxt;
    logic [BE_W-1:0]   mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              i_gnt_nxt, d_gnt_nxt;
    logic              i_rvalid_nxt, d_rvalid_nxt;
    logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
    logic              i_err_nxt, d_err_nxt;

    // Saturating increment of the data-grant streak.
    function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] v);
        return (v == STREAK_MAX) ? v : v + 1'b1;
    endfunction

    // Next-state, arbitration, timeout and response formation.
    always_comb begin
        state_nxt     = state;
        streak_nxt    = streak;
        tcnt_nxt      = tcnt;
        owner_d_nxt   = owner_d;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        i_gnt_nxt     = 1'b0;
        d_gnt_nxt     = 1'b0;
        i_rvalid_nxt  = 1'b0;
        d_rvalid_nxt  = 1'b0;
        i_rdata_nxt   = i_rdata;
        d_rdata_nxt   = d_rdata;
        i_err_nxt     = i_err;
        d_err_nxt     = d_err;
        done          = 1'b0;
        tmo           = 1'b0;
        rsp_data      = '0;
        tcnt_inc      = tcnt + 1'b1;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    if (d_req && !(i_req && streak == STREAK_MAX)) begin
                        owner_d_nxt   = 1'b1;
                        d_gnt_nxt     = 1'b1;
                        mem_we_nxt    = d_we;
                        mem_addr_nxt  = d_addr;
                        mem_wdata_nxt = d_wdata;
                        // the streak only counts grants that actually made fetch wait
                        streak_nxt    = i_req ? streak_inc(streak) : '0;
                    end else begin
                        owner_d_nxt   = 1'b0;
                        i_gnt_nxt     = 1'b1;
                        mem_we_nxt    = '0;
                        mem_addr_nxt  = i_addr;
                        mem_wdata_nxt = '0;
                        streak_nxt    = '0;
                    end
                    mem_req_nxt = 1'b1;
                    tcnt_nxt    = '0;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_nxt = tcnt_inc;
                // mem_rvalid without mem_ready is not a completion
                if (mem_ready) begin
                    mem_req_nxt = 1'b0;
                    if (mem_rvalid) begin
                        done = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
                tmo = !done && (tcnt_inc == TMO_LIMIT);
            end
            WAIT: begin
                tcnt_nxt = tcnt_inc;
                done     = mem_rvalid;
                tmo      = !done && (tcnt_inc == TMO_LIMIT);
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase

        if (done || tmo) begin
            state_nxt   = IDLE;
            mem_req_nxt = 1'b0;
            // writes and timed-out accesses return zero data
            rsp_data    = (done && mem_we == '0) ? mem_rdata : '0;
            if (owner_d) begin
                d_rvalid_nxt = 1'b1;
                d_rdata_nxt  = rsp_data;
                d_err_nxt    = tmo;
            end else begin
                i_rvalid_nxt = 1'b1;
                i_rdata_nxt  = rsp_data;
                i_err_nxt    = tmo;
            end
        end
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            streak    <= '0;
            tcnt      <= '0;
            owner_d   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_err     <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            tcnt      <= tcnt_nxt;
            owner_d   <= owner_d_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            i_gnt     <= i_gnt_nxt;
            d_gnt     <= d_gnt_nxt;
            i_rvalid  <= i_rvalid_nxt;
            d_rvalid  <= d_rvalid_nxt;
            i_rdata   <= i_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            i_err     <= i_err_nxt;
            d_err     <= d_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts grants,
// memory request and responses every cycle; directed tests add literal checks.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXD = 2;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_gnt, i_rvalid, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [BW-1:0] d_we = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int            ready_dly = 0;
    int            rv_dly = 1;
    bit            no_rv = 1'b0;
    bit            stray = 1'b0;
    logic [DW-1:0] rsp_data = '0;
    int            rcnt = 0;
    int            wcnt = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!rstn) begin
                rcnt = 0;
                wcnt = -1;
            end else begin
                if (wcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp_data;
                    wcnt = -1;
                end else if (wcnt > 0) begin
                    wcnt--;
                end
                if (stray) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hFFFF_FFFF;
                    stray = 1'b0;
                end
                if (mem_req) begin
                    if (rcnt == ready_dly) begin
                        mem_ready = 1'b1;
                        rcnt = 0;
                        if (!no_rv) begin
                            if (rv_dly == 0) begin
                                mem_rvalid = 1'b1;
                                mem_rdata  = rsp_data;
                            end else begin
                                wcnt = rv_dly - 1;
                            end
                        end
                    end else begin
                        rcnt++;
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    // ---------------- transaction-level model ----------------
    bit            m_busy = 1'b0, m_owner_d = 1'b0, m_acc = 1'b0, m_pick_d, m_fin;
    int            m_age = 0, m_streak = 0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_we = '0;
    logic [DW-1:0] m_wdata = '0, m_rsp;
    bit            e_i_gnt = 1'b0, e_d_gnt = 1'b0, e_mem_req = 1'b0;
    bit            e_i_rv = 1'b0, e_d_rv = 1'b0, e_i_err = 1'b0, e_d_err = 1'b0;
    logic [DW-1:0] e_i_rdata = '0, e_d_rdata = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_busy = 1'b0; m_streak = 0;
                e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_mem_req = 1'b0;
                e_i_rv = 1'b0; e_d_rv = 1'b0;
            end else begin
                e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_i_rv = 1'b0; e_d_rv = 1'b0;
                if (!m_busy) begin
                    if (i_req || d_req) begin
                        m_pick_d = d_req && !(i_req && m_streak == MAXD);
                        if (m_pick_d)
                            m_streak = i_req ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
                        else
                            m_streak = 0;
                        m_owner_d = m_pick_d;
                        m_busy = 1'b1; m_acc = 1'b0; m_age = 0;
                        m_addr  = m_pick_d ? d_addr : i_addr;
                        m_we    = m_pick_d ? d_we : '0;
                        m_wdata = d_wdata;
                        e_d_gnt = m_pick_d;
                        e_i_gnt = !m_pick_d;
                    end
                end else begin
                    m_age++;
                    m_fin = 1'b0;
                    if (!m_acc) begin
                        if (mem_ready) begin
                            m_acc = 1'b1;
                            m_fin = mem_rvalid;
                        end
                    end else begin
                        m_fin = mem_rvalid;
                    end
                    if (m_fin || m_age == TMO) begin
                        m_rsp = (m_fin && m_we == '0) ? mem_rdata : '0;
                        if (m_owner_d) begin
                            e_d_rv = 1'b1; e_d_rdata = m_rsp; e_d_err = !m_fin;
                        end else begin
                            e_i_rv = 1'b1; e_i_rdata = m_rsp; e_i_err = !m_fin;
                        end
                        m_busy = 1'b0;
                    end
                end
                e_mem_req = m_busy && !m_acc;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("i_gnt", i_gnt, e_i_gnt);
            chk("d_gnt", d_gnt, e_d_gnt);
            chk("i_rvalid", i_rvalid, e_i_rv);
            chk("d_rvalid", d_rvalid, e_d_rv);
            chk("mem_req", mem_req, e_mem_req);
            if (e_mem_req) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, m_we);
                if (m_owner_d) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (e_i_rv) begin
                chk("i_rdata", i_rdata, e_i_rdata);
                chk("i_err", i_err, e_i_err);
            end
            if (e_d_rv) begin
                chk("d_rdata", d_rdata, e_d_rdata);
                chk("d_err", d_err, e_d_err);
            end
            if (!rstn) begin
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_i_rdata", i_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
                chk("rst_errs", {i_err, d_err}, 0);
            end
        end
    end

    // grant order log for the starvation test
    bit   log_on = 1'b0;
    byte  glog[$];
    always @(negedge clk) begin
        if (log_on && i_gnt) glog.push_back("I");
        if (log_on && d_gnt) glog.push_back("D");
    end

    // ---------------- helpers ----------------
    int g_cyc = 0, r_cyc = 0;

    task automatic wait_gnt(output bit got_d, output logic [AW-1:0] a,
                            output logic [BW-1:0] we, output logic [DW-1:0] wd);
        bit seen;
        seen = 1'b0; got_d = 1'b0; a = '0; we = '0; wd = '0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (i_gnt || d_gnt) begin
                seen = 1'b1; got_d = d_gnt;
                a = mem_addr; we = mem_we; wd = mem_wdata; g_cyc = cyc;
            end
        end
        chk("gnt_within_bound", seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input bit is_d, output logic [DW-1:0] rd, output logic er);
        bit seen;
        seen = 1'b0; rd = '0; er = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (is_d ? d_rvalid : i_rvalid) begin
                seen = 1'b1;
                rd = is_d ? d_rdata : i_rdata;
                er = is_d ? d_err : i_err;
                r_cyc = cyc;
            end
        end
        chk("rsp_within_bound", seen, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    bit            gd;
    logic [AW-1:0] ga;
    logic [BW-1:0] gw;
    logic [DW-1:0] gwd, rd;
    logic          re;
    string         exp_ord = "DDIDDI";

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_pulses", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // instruction-only read
        ready_dly = 1; rv_dly = 2; no_rv = 1'b0; rsp_data = 32'hDEAD_BEEF;
        i_addr = 32'h100; i_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        i_req = 1'b0;
        chk("t1_gnt_is_i", gd, 0);
        chk("t1_mem_addr", ga, 32'h100);
        chk("t1_mem_we", gw, 0);
        wait_rsp(1'b0, rd, re);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_err", re, 0);

        // simultaneous requests: data first, then instruction
        ready_dly = 0; rv_dly = 1; rsp_data = 32'h5555_AAAA;
        i_addr = 32'h400; d_addr = 32'h200; d_we = '0;
        i_req = 1'b1; d_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        d_req = 1'b0;
        chk("t2_first_is_d", gd, 1);
        chk("t2_first_addr", ga, 32'h200);
        wait_rsp(1'b1, rd, re);
        chk("t2_d_rdata", rd, 32'h5555_AAAA);
        wait_gnt(gd, ga, gw, gwd);
        i_req = 1'b0;
        chk("t2_second_is_i", gd, 0);
        chk("t2_second_addr", ga, 32'h400);
        wait_rsp(1'b0, rd, re);

        // byte store with same-cycle completion
        ready_dly = 0; rv_dly = 0; rsp_data = 32'h1234_5678;
        d_we = 4'b0100; d_wdata = 32'h00AB_0000; d_addr = 32'h300; d_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        d_req = 1'b0; d_we = '0;
        chk("t3_gnt_is_d", gd, 1);
        chk("t3_mem_addr", ga, 32'h300);
        chk("t3_mem_we", gw, 4'b0100);
        chk("t3_mem_wdata", gwd, 32'h00AB_0000);
        wait_rsp(1'b1, rd, re);
        chk("t3_rdata_zero", rd, 0);
        chk("t3_err", re, 0);

        // starvation limit: both requests held continuously
        ready_dly = 0; rv_dly = 1; rsp_data = 32'hCAFE_0000;
        i_addr = 32'h500; d_addr = 32'h600; d_we = '0;
        glog.delete();
        log_on = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 200 && glog.size() < 6; k++) begin
            @(posedge clk);
            #1;
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("t4_six_grants", (glog.size() >= 6), 1);
        repeat (8) @(posedge clk);
        #1;
        log_on = 1'b0;
        for (int k = 0; k < 6; k++) begin
            byte want;
            byte got;
            want = exp_ord[k];
            got  = (k < glog.size()) ? glog[k] : 8'd0;
            chk($sformatf("t4_order%0d", k), got, want);
        end

        // timeout, stray completion, then normal service
        ready_dly = 0; no_rv = 1'b1;
        d_addr = 32'h700; d_we = '0; d_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        d_req = 1'b0;
        wait_rsp(1'b1, rd, re);
        chk("t5_latency", r_cyc - g_cyc, TMO);
        chk("t5_err", re, 1);
        chk("t5_rdata_zero", rd, 0);
        stray = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        no_rv = 1'b0; rv_dly = 1; rsp_data = 32'h0BAD_F00D;
        i_addr = 32'h800; i_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        i_req = 1'b0;
        chk("t5_next_is_i", gd, 0);
        wait_rsp(1'b0, rd, re);
        chk("t5_next_rdata", rd, 32'h0BAD_F00D);
        chk("t5_next_err", re, 0);

        // reset in WAIT after building a full data streak
        ready_dly = 0; rv_dly = 1; rsp_data = 32'h7777_0000;
        i_addr = 32'h900; d_addr = 32'hA00; d_we = '0;
        i_req = 1'b1; d_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        chk("t6_first_is_d", gd, 1);
        rv_dly = 6;
        wait_gnt(gd, ga, gw, gwd);
        chk("t6_second_is_d", gd, 1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        i_req = 1'b0; d_req = 1'b0;
        #1;
        chk("t6_rst_mem_req", mem_req, 0);
        chk("t6_rst_pulses", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rv_dly = 1;
        repeat (6) @(posedge clk);
        #1;
        i_req = 1'b1; d_req = 1'b1;
        wait_gnt(gd, ga, gw, gwd);
        d_req = 1'b0;
        chk("t6_after_rst_is_d", gd, 1);
        chk("t6_after_rst_addr", ga, 32'hA00);
        wait_rsp(1'b1, rd, re);
        wait_gnt(gd, ga, gw, gwd);
        i_req = 1'b0;
        chk("t6_then_i", gd, 0);
        wait_rsp(1'b0, rd, re);
        chk("t6_i_rdata", rd, 32'h7777_0000);
        repeat (4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
